pulse_width_encoder: RTL and testbench
======================================

PULSE_WIDTH_ENCODER -- requirements
Module: pulse_width_encoder

Interface
REQ-001 Parameter DEPTH, default 249, number of transducer elements per frame.
REQ-002 Parameter LATENCY, default 3, fixed DIN_VALID-to-DOUT_VALID delay in CLK cycles.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 DIN_VALID  input  1  qualifies INTENSITY_IN/PHASE_IN, one element per cycle, from the intensity interpolator.
REQ-006 INTENSITY_IN  input  16  interpolated intensity.
REQ-007 PHASE_IN  input  8  phase of same element, time-aligned with INTENSITY_IN.
REQ-008 FULL_WIDTH_START  input  16  intensity threshold for full-width pulse; quasi-static.
REQ-009 TABLE_WE  input  1  pulse-width table write strobe.
REQ-010 TABLE_ADDR  input  15  table write address.
REQ-011 TABLE_DATA  input  8  table write data.
REQ-012 PULSE_WIDTH_OUT  output  9  encoded pulse width, 0..256.
REQ-013 PHASE_OUT  output  8  phase delayed to match PULSE_WIDTH_OUT.
REQ-014 IDX_OUT  output  8  element index of current output, 0..DEPTH-1.
REQ-015 DOUT_VALID  output  1  qualifies PULSE_WIDTH_OUT/PHASE_OUT/IDX_OUT.
REQ-016 OVERRUN  output  1  sticky: frame exceeded DEPTH elements.

Function
REQ-017 Internal table: 32768x8, one write port (TABLE_*), one registered read port, 2-cycle read latency.
REQ-018 Read address = INTENSITY_IN[15:1], sampled in the DIN_VALID cycle.
REQ-019 Encoding: INTENSITY >= FULL_WIDTH_START (unsigned) -> 256; else {1'b0, table[INTENSITY[15:1]]}.
REQ-020 Compare uses the intensity and the FULL_WIDTH_START value sampled with that element; pipelined alongside the table read.
REQ-021 DOUT_VALID asserts exactly LATENCY cycles after each DIN_VALID; one output per input, order preserved, no stalls, no backpressure.
REQ-022 PHASE_OUT = PHASE_IN delayed LATENCY cycles, unmodified.
REQ-023 Gaps in DIN_VALID propagate as gaps in DOUT_VALID; output registers hold last value when DOUT_VALID=0.
REQ-024 State machine: IDLE -> RUN on first DIN_VALID; RUN -> IDLE after DEPTH-th element accepted, or when DIN_VALID low for 2 consecutive cycles (frame end).
REQ-025 Input index counter: 0 on entering RUN, +1 per accepted element; returns to 0 in IDLE.
REQ-026 IDX_OUT = input index of that element, delayed with data.
REQ-027 If DIN_VALID high in the cycle after the DEPTH-th element without an intervening frame end, index wraps to 0, new frame begins, and OVERRUN sets.
REQ-028 OVERRUN cleared only by RST.
REQ-029 Simultaneous table write and read at same address: read returns old data; write visible from the next cycle's read.
REQ-030 Table writes permitted in any state; do not disturb in-flight pipeline except per REQ-029.

Reset
REQ-031 RST assertion immediately: DOUT_VALID=0, PULSE_WIDTH_OUT=0, PHASE_OUT=0, IDX_OUT=0, OVERRUN=0, state IDLE, index 0, pipeline valid bits cleared.
REQ-032 Table contents not cleared by RST.
REQ-033 RST mid-frame discards all in-flight elements; no DOUT_VALID until LATENCY cycles after the first DIN_VALID following deassertion.
REQ-034 DIN_VALID during RST ignored.

Verification
REQ-035 Load table[i]=i[7:0]; FULL_WIDTH_START=0xFFFF; stream 249 elements INTENSITY=2*k, PHASE=k -> 249 outputs, 3 cycles late, PULSE_WIDTH=k[7:0], IDX=k, OVERRUN=0.
REQ-036 FULL_WIDTH_START=0x8000; INTENSITY 0x7FFF then 0x8000 -> PULSE_WIDTH table[0x3FFF] then 256.
REQ-037 Stream of 250 back-to-back elements -> 250th output IDX=0, OVERRUN=1 and stays 1 until RST.
REQ-038 TABLE_WE addr 0x0010 data 0x55 (old 0x11) in same cycle as DIN_VALID with INTENSITY=0x0020 -> output 0x011; same intensity next cycle -> 0x055.
REQ-039 RST pulsed mid-frame at element 100 -> outputs zero immediately, no stale DOUT_VALID; next frame starts IDX=0.
REQ-040 DIN_VALID pattern 1,0,1,0,0,1 -> DOUT_VALID same pattern shifted 3 cycles; IDX 0,1,0 (frame end after two low cycles).

Source files
------------

// File: rtl/pulse_width_encoder_if.sv
// Element stream, table-load port and encoded output of the pulse-width encoder.
interface pulse_width_encoder_if;
  logic        din_valid;
  logic [15:0] intensity;
  logic [7:0]  phase_in;
  logic [15:0] full_width_start;
  logic        table_we;
  logic [14:0] table_addr;
  logic [7:0]  table_data;
  logic [8:0]  pulse_width;
  logic [7:0]  phase_out;
  logic [7:0]  idx;
  logic        dout_valid;
  logic        overrun;

  modport slave (
    input  din_valid, intensity, phase_in, full_width_start,
    input  table_we, table_addr, table_data,
    output pulse_width, phase_out, idx, dout_valid, overrun
  );

  modport master (
    output din_valid, intensity, phase_in, full_width_start,
    output table_we, table_addr, table_data,
    input  pulse_width, phase_out, idx, dout_valid, overrun
  );
endinterface

// File: rtl/pulse_width_encoder.sv
// Maps interpolated intensity to a transducer pulse width through a loadable table,
// tagging each element with its in-frame index and flagging frames longer than DEPTH.
module pulse_width_encoder #(
  parameter int unsigned DEPTH   = 249,
  parameter int unsigned LATENCY = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pulse_width_encoder_if.slave  bus
);
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned NSTG   = LATENCY - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic             valid;
    logic             full;
    logic [7:0]       data;
    logic [7:0]       phase;
    logic [IDX_W-1:0] idx;
  } stage_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, elem_idx_c;
  logic             gap_q, gap_d;
  logic             wrap_q, wrap_d;
  logic             overrun_q, overrun_d;

  logic [7:0]       tbl_mem [2**ADDR_W];
  logic [7:0]       rd_q;
  stage_t           pipe_q [NSTG];

  logic             dout_valid_q;
  logic [8:0]       pw_q;
  logic [7:0]       phase_q;
  logic [IDX_W-1:0] idx_q;

  // Frame tracking state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= 1'b0;
      wrap_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      wrap_q    <= wrap_d;
      overrun_q <= overrun_d;
    end
  end

  // wrap_q marks the cycle right after a full frame; an element there is an overrun
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    wrap_d     = 1'b0;
    overrun_d  = overrun_q;
    elem_idx_c = (state_q == RUN) ? cnt_q : '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        gap_d = 1'b0;
        if (bus.din_valid) begin
          if (wrap_q) overrun_d = 1'b1;
          if (elem_idx_c == LAST_IDX) begin
            wrap_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = IDX_W'(1);
          end
        end
      end
      RUN: begin
        if (bus.din_valid) begin
          gap_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            cnt_d   = '0;
            wrap_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (gap_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          gap_d   = 1'b0;
        end else begin
          gap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Table: read samples pre-write contents, so a same-cycle write is seen one cycle later
  always_ff @(posedge clk_i) begin
    if (bus.table_we) tbl_mem[bus.table_addr] <= bus.table_data;
    rd_q <= tbl_mem[bus.intensity[15:1]];
  end

  // Sideband pipeline aligned with the two-cycle table read, then holding output stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NSTG); k++) pipe_q[k] <= '0;
      dout_valid_q <= 1'b0;
      pw_q         <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
    end else begin
      pipe_q[0] <= '{valid: bus.din_valid,
                     full:  (bus.intensity >= bus.full_width_start),
                     data:  8'h00,
                     phase: bus.phase_in,
                     idx:   elem_idx_c};
      pipe_q[1] <= '{valid: pipe_q[0].valid,
                     full:  pipe_q[0].full,
                     data:  rd_q,
                     phase: pipe_q[0].phase,
                     idx:   pipe_q[0].idx};
      for (int k = 2; k < int'(NSTG); k++) pipe_q[k] <= pipe_q[k-1];
      dout_valid_q <= pipe_q[NSTG-1].valid;
      if (pipe_q[NSTG-1].valid) begin
        pw_q    <= pipe_q[NSTG-1].full ? 9'd256 : {1'b0, pipe_q[NSTG-1].data};
        phase_q <= pipe_q[NSTG-1].phase;
        idx_q   <= pipe_q[NSTG-1].idx;
      end
    end
  end

  assign bus.dout_valid  = dout_valid_q;
  assign bus.pulse_width = pw_q;
  assign bus.phase_out   = phase_q;
  assign bus.idx         = idx_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_pulse_width_encoder.sv
// Randomized and directed checks of pulse_width_encoder against a frame/table reference model.
module tb_pulse_width_encoder;
  localparam int DEPTH   = 249;
  localparam int LATENCY = 3;

  typedef struct {
    int         due;
    logic [8:0] pw;
    logic [7:0] ph;
    logic [7:0] idx;
  } exp_t;

  logic clk;
  logic rst;
  pulse_width_encoder_if bus_if();

  pulse_width_encoder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         stepn    = 0;
  exp_t       q[$];
  exp_t       last;
  logic [7:0] m_tbl [32768];
  int         m_cnt;
  int         m_lows;
  logic       m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, stepn);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    last   = '{due: 0, pw: 9'd0, ph: 8'd0, idx: 8'd0};
    m_cnt  = 0;
    m_lows = 2;
    m_ovr  = 1'b0;
  endfunction

  // One clock: check what the DUT shows now, then drive the next input and predict it
  task automatic step(input logic v, input logic [15:0] inten, input logic [7:0] ph,
                      input logic we = 1'b0, input logic [14:0] wa = 15'd0,
                      input logic [7:0] wd = 8'd0);
    exp_t e;
    logic exp_v;
    @(negedge clk);
    exp_v = (q.size() > 0) && (q[0].due == stepn);
    check_eq("dout_valid", 32'(bus_if.dout_valid), 32'(exp_v));
    if (exp_v) last = q.pop_front();
    check_eq("pulse_width", 32'(bus_if.pulse_width), 32'(last.pw));
    check_eq("phase_out", 32'(bus_if.phase_out), 32'(last.ph));
    check_eq("idx_out", 32'(bus_if.idx), 32'(last.idx));
    check_eq("overrun", 32'(bus_if.overrun), 32'(m_ovr));

    bus_if.din_valid  = v;
    bus_if.intensity  = inten;
    bus_if.phase_in   = ph;
    bus_if.table_we   = we;
    bus_if.table_addr = wa;
    bus_if.table_data = wd;

    if (v) begin
      if (m_lows >= 2) m_cnt = 0;
      if (m_cnt == DEPTH) begin
        m_cnt = 0;
        if (m_lows == 0) m_ovr = 1'b1;
      end
      e.due = stepn + LATENCY;
      e.ph  = ph;
      e.idx = 8'(m_cnt);
      e.pw  = (inten >= bus_if.full_width_start) ? 9'd256 : {1'b0, m_tbl[inten[15:1]]};
      q.push_back(e);
      m_cnt++;
      m_lows = 0;
    end else if (m_lows < 2) begin
      m_lows++;
    end
    if (we) m_tbl[wa] = wd;
    stepn++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 8'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus_if.din_valid = 1'b1;
    bus_if.table_we  = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_dout_valid", 32'(bus_if.dout_valid), 32'd0);
    check_eq("rst_pulse_width", 32'(bus_if.pulse_width), 32'd0);
    check_eq("rst_phase_out", 32'(bus_if.phase_out), 32'd0);
    check_eq("rst_idx_out", 32'(bus_if.idx), 32'd0);
    check_eq("rst_overrun", 32'(bus_if.overrun), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_ignores_din", 32'(bus_if.dout_valid), 32'd0);
    bus_if.din_valid = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus_if.din_valid        = 1'b0;
    bus_if.intensity        = 16'd0;
    bus_if.phase_in         = 8'd0;
    bus_if.full_width_start = 16'hFFFF;
    bus_if.table_we         = 1'b0;
    bus_if.table_addr       = 15'd0;
    bus_if.table_data       = 8'd0;
    model_reset();
    apply_reset();

    // Table load: identity over the low region plus one marker entry
    for (int i = 0; i < 512; i++) step(1'b0, 16'd0, 8'd0, 1'b1, 15'(i), 8'(i));
    step(1'b0, 16'd0, 8'd0, 1'b1, 15'h3FFF, 8'hA5);

    // Full frame of DEPTH elements, intensity 2k -> width k
    for (int k = 0; k < DEPTH; k++) step(1'b1, 16'(2 * k), 8'(k));
    idle(4);

    // Sparse valid pattern with a frame end between the 2nd and 3rd element
    step(1'b1, 16'd10, 8'd1);
    step(1'b0, 16'd0, 8'd0);
    step(1'b1, 16'd12, 8'd2);
    step(1'b0, 16'd0, 8'd0);
    step(1'b0, 16'd0, 8'd0);
    step(1'b1, 16'd14, 8'd3);
    idle(4);

    // Full-width threshold boundary
    bus_if.full_width_start = 16'h8000;
    step(1'b1, 16'h7FFF, 8'h11);
    step(1'b1, 16'h8000, 8'h22);
    idle(4);
    bus_if.full_width_start = 16'hFFFF;

    // Write and read of the same entry in one cycle
    step(1'b0, 16'd0, 8'd0, 1'b1, 15'h0010, 8'h11);
    step(1'b1, 16'h0020, 8'h33, 1'b1, 15'h0010, 8'h55);
    step(1'b1, 16'h0020, 8'h34);
    idle(4);

    // Overrun: DEPTH+1 back-to-back elements
    for (int k = 0; k <= DEPTH; k++) step(1'b1, 16'($urandom_range(0, 1023)), 8'($urandom));
    idle(6);

    // Reset mid-frame, then a fresh frame
    for (int k = 0; k < 100; k++) step(1'b1, 16'($urandom_range(0, 1023)), 8'(k));
    apply_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 16'($urandom_range(0, 1023)), 8'(k));
    idle(4);

    // Random streams with concurrent table writes and varying threshold
    for (int blk = 0; blk < 8; blk++) begin
      int unsigned fws;
      idle(3);
      fws = $urandom_range(16'h0400, 16'hFFFF);
      bus_if.full_width_start = 16'(fws);
      for (int n = 0; n < 250; n++) begin
        logic        v;
        logic [15:0] inten;
        logic        we;
        v     = ($urandom_range(0, 9) < 8);
        inten = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(fws, 16'hFFFF))
                                            : 16'($urandom_range(0, 1023));
        we    = ($urandom_range(0, 4) == 0);
        step(v, inten, 8'($urandom), we, 15'($urandom_range(0, 511)), 8'($urandom));
      end
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
